// File: rtl/fp_pkg.sv
// Shared floating-point datapath constants and types.
// Result capture sizing derives from the adder width.
package fp_pkg;

  localparam int FP_W = 32;

  localparam int RC_DATA_W = FP_W;
  localparam int RC_DEPTH  = 4;

  typedef struct packed {
    logic push;
    logic pop;
    logic drop;
  } rc_ctl_t;

endpackage

// File: rtl/result_capture_if.sv
// Handshake bundle between the adder delay stage,
// the result capture buffer and its consumer.
interface result_capture_if
  import fp_pkg::*;
#(
  parameter int DATA_W = RC_DATA_W,
  parameter int DEPTH  = RC_DEPTH
);

  logic                     done_in;
  logic [DATA_W-1:0]        sum_in;
  logic                     clr_in;
  logic                     res_ready_in;
  logic [DATA_W-1:0]        res_out;
  logic                     res_valid_out;
  logic [$clog2(DEPTH):0]   count_out;
  logic                     full_out;
  logic                     overflow_out;

  modport master (
    output done_in,
    output sum_in,
    output clr_in,
    output res_ready_in,
    input  res_out,
    input  res_valid_out,
    input  count_out,
    input  full_out,
    input  overflow_out
  );

  modport slave (
    input  done_in,
    input  sum_in,
    input  clr_in,
    input  res_ready_in,
    output res_out,
    output res_valid_out,
    output count_out,
    output full_out,
    output overflow_out
  );

endinterface

// File: rtl/result_fifo.sv
// Circular result store: pointers, occupancy count
// and unreset storage array.
module result_fifo
  import fp_pkg::*;
#(
  parameter int DATA_W = RC_DATA_W,
  parameter int DEPTH  = RC_DEPTH
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       push_in,
  input  logic                       pop_in,
  input  logic [DATA_W-1:0]          wdata_in,
  output logic [DATA_W-1:0]          rdata_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       empty_out,
  output logic                       full_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_in) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_in)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_in, pop_in})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data array needs no reset; count gates visibility.
  always_ff @(posedge clk_in) begin
    if (push_in) mem_q[wr_ptr_q] <= wdata_in;
  end

  assign empty_out = (count_q == '0);
  assign full_out  = (count_q == CW'(DEPTH));
  assign count_out = count_q;
  assign rdata_out = empty_out ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/result_capture.sv
// Captures adder results into a small buffer,
// qualifies push/pop and tracks lost results.
module result_capture
  import fp_pkg::*;
#(
  parameter int DATA_W = RC_DATA_W,
  parameter int DEPTH  = RC_DEPTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  result_capture_if.slave  bus
);

  rc_ctl_t ctl;
  logic    empty;
  logic    full;
  logic    overflow_q, overflow_d;

  always_comb begin
    ctl      = '0;
    ctl.pop  = !empty && bus.res_ready_in;
    ctl.push = bus.done_in && (!full || ctl.pop);
    ctl.drop = bus.done_in && full && !ctl.pop;
  end

  // Set has priority over clear.
  always_comb begin
    overflow_d = overflow_q;
    if (ctl.drop)        overflow_d = 1'b1;
    else if (bus.clr_in) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) overflow_q <= 1'b0;
    else           overflow_q <= overflow_d;
  end

  result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push_in   (ctl.push),
    .pop_in    (ctl.pop),
    .wdata_in  (bus.sum_in),
    .rdata_out (bus.res_out),
    .count_out (bus.count_out),
    .empty_out (empty),
    .full_out  (full)
  );

  assign bus.res_valid_out = !empty;
  assign bus.full_out      = full;
  assign bus.overflow_out  = overflow_q;

endmodule

// File: tb/tb_result_capture.sv
// Randomized and directed bench for result_capture
// against a queue-based reference model.
module tb_result_capture;

  localparam int DW = 32;
  localparam int DP = 4;

  logic clk;
  logic rst_n;

  result_capture_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  result_capture #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mq[$];
  bit            movf;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [DW-1:0] er;
    er = (mq.size() != 0) ? mq[0] : '0;
    chk("valid", bus.res_valid_out, mq.size() != 0);
    chk("data", bus.res_out, er);
    chk("count", bus.count_out, mq.size());
    chk("full", bus.full_out, mq.size() == DP);
    chk("ovf", bus.overflow_out, movf);
  endtask

  task automatic model_edge();
    bit pop, full, push, drop;
    full = (mq.size() == DP);
    pop  = (mq.size() != 0) && bus.res_ready_in;
    push = bus.done_in && (!full || pop);
    drop = bus.done_in && full && !pop;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(bus.sum_in);
    if (drop)            movf = 1'b1;
    else if (bus.clr_in) movf = 1'b0;
  endtask

  task automatic cyc(bit d, logic [DW-1:0] s, bit c, bit r);
    bus.done_in      = d;
    bus.sum_in       = s;
    bus.clr_in       = c;
    bus.res_ready_in = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DP + 1; i++) cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.done_in      = 1'b0;
    bus.sum_in       = '0;
    bus.clr_in       = 1'b0;
    bus.res_ready_in = 1'b0;
    movf             = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle();

    cyc(1'b1, 32'h3FC0_0000, 1'b0, 1'b0);
    chk("first_data", bus.res_out, 32'h3FC0_0000);
    drain();

    cyc(1'b1, 32'h3F80_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h4000_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h4040_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h4080_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h40A0_0000, 1'b0, 1'b0);
    chk("ovf_full", bus.overflow_out, 1'b1);
    cyc(1'b1, 32'h4100_0000, 1'b0, 1'b1);
    chk("cnt_hold", bus.count_out, DP);
    drain();

    cyc(1'b1, 32'h1111_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h2222_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h3333_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h4444_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h5555_0000, 1'b1, 1'b0);
    chk("set_wins", bus.overflow_out, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("clr", bus.overflow_out, 1'b0);
    drain();

    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) cyc(1'b1, $urandom, 1'b0, 1'b1);
      else            cyc(1'b0, '0, 1'b0, 1'b1);
    end

    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b0);
    bus.done_in = 1'b0;
    #2 rst_n = 1'b0;
    mq.delete();
    movf = 1'b0;
    #1 check_all();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_all();
    idle();

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 3) != 0, $urandom,
          ($urandom % 8) == 0, ($urandom % 3) == 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
